// File: rtl/dqn_pkg.sv
// Shared types and constants for the output-layer bias path.
// Used by the delta generator and the bias bank.
package dqn_pkg;

    typedef enum logic [1:0] {
        ACC    = 2'd0,
        SCALE  = 2'd1,
        UPDATE = 2'd2
    } state_e;

    localparam logic [3:0]  CTRL_UPDATE = 4'b1111;
    localparam int unsigned DELTA_W     = 16;
    localparam int          DELTA_MAX   = 32767;
    localparam int          DELTA_MIN   = -32768;

endpackage

// File: rtl/bias2_sat_lane.sv
// One lane: arithmetic right shift of the batch sum by the learning-rate
// exponent, then clamp to the signed 16-bit delta range. Purely combinational.
module bias2_sat_lane
    import dqn_pkg::*;
#(
    parameter int unsigned ACC_W = 35,
    parameter int unsigned SHIFT = 6
) (
    input  logic [ACC_W-1:0]   acc_i,
    output logic [DELTA_W-1:0] delta_o
);

    logic signed [ACC_W-1:0] shifted;

    always_comb begin
        shifted = $signed(acc_i) >>> SHIFT;
        if (shifted > $signed(ACC_W'(DELTA_MAX))) begin
            delta_o = DELTA_W'(DELTA_MAX);
        end else if (shifted < $signed(ACC_W'(DELTA_MIN))) begin
            delta_o = DELTA_W'(DELTA_MIN);
        end else begin
            delta_o = shifted[DELTA_W-1:0];
        end
    end

endmodule

// File: rtl/bias2_delta_gen.sv
// Accumulates 5-lane error vectors over a minibatch, scales by 2^-LR_SHIFT,
// saturates and issues a one-cycle bias-bank update strobe per batch.
module bias2_delta_gen
    import dqn_pkg::*;
#(
    parameter int unsigned BATCH    = 4,
    parameter int unsigned LR_SHIFT = 6,
    parameter int unsigned ERR_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             err_valid,
    output logic             err_ready,
    input  logic [ERR_W-1:0] err_1,
    input  logic [ERR_W-1:0] err_2,
    input  logic [ERR_W-1:0] err_3,
    input  logic [ERR_W-1:0] err_4,
    input  logic [ERR_W-1:0] err_5,
    input  logic             flush,
    output logic [3:0]       ctrl,
    output logic [3:0]       sel,
    output logic [15:0]      deltab2_1,
    output logic [15:0]      deltab2_2,
    output logic [15:0]      deltab2_3,
    output logic [15:0]      deltab2_4,
    output logic [15:0]      deltab2_5,
    output logic [15:0]      upd_cnt
);

    localparam int unsigned LANES = 5;
    // One guard bit beyond clog2(BATCH) keeps a full batch of extreme values exact.
    localparam int unsigned ACC_W = ERR_W + $clog2(BATCH) + 1;
    localparam int unsigned CNT_W = $clog2(BATCH + 1);

    state_e                   state_q, state_d;
    logic signed [ERR_W-1:0]  err_v   [LANES];
    logic [ACC_W-1:0]         acc_q   [LANES];
    logic [ACC_W-1:0]         acc_d   [LANES];
    logic [DELTA_W-1:0]       sat_c   [LANES];
    logic [DELTA_W-1:0]       delta_q [LANES];
    logic [DELTA_W-1:0]       delta_d [LANES];
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [15:0]              upd_cnt_q, upd_cnt_d;
    logic                     accept_c;
    logic [CNT_W-1:0]         cnt_inc_c;

    assign err_v[0] = err_1;
    assign err_v[1] = err_2;
    assign err_v[2] = err_3;
    assign err_v[3] = err_4;
    assign err_v[4] = err_5;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        bias2_sat_lane #(
            .ACC_W (ACC_W),
            .SHIFT (LR_SHIFT)
        ) u_sat (
            .acc_i   (acc_q[g]),
            .delta_o (sat_c[g])
        );
    end

    // Next-state and datapath update.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        upd_cnt_d = upd_cnt_q;
        for (int i = 0; i < LANES; i++) begin
            acc_d[i]   = acc_q[i];
            delta_d[i] = delta_q[i];
        end
        accept_c  = err_valid && (state_q == ACC);
        cnt_inc_c = cnt_q + CNT_W'(1);

        unique case (state_q)
            ACC: begin
                if (accept_c) begin
                    cnt_d = cnt_inc_c;
                    for (int i = 0; i < LANES; i++) begin
                        acc_d[i] = acc_q[i] + ACC_W'(err_v[i]);
                    end
                end
                if ((accept_c && (cnt_inc_c == CNT_W'(BATCH))) ||
                    (flush && ((cnt_q != '0) || accept_c))) begin
                    state_d = SCALE;
                end
            end
            SCALE: begin
                for (int i = 0; i < LANES; i++) begin
                    delta_d[i] = sat_c[i];
                end
                state_d = UPDATE;
            end
            UPDATE: begin
                for (int i = 0; i < LANES; i++) begin
                    acc_d[i] = '0;
                end
                cnt_d     = '0;
                upd_cnt_d = upd_cnt_q + 16'd1;
                state_d   = ACC;
            end
            default: begin
                state_d = ACC;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ACC;
            cnt_q     <= '0;
            upd_cnt_q <= '0;
            for (int i = 0; i < LANES; i++) begin
                acc_q[i]   <= '0;
                delta_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            upd_cnt_q <= upd_cnt_d;
            for (int i = 0; i < LANES; i++) begin
                acc_q[i]   <= acc_d[i];
                delta_q[i] <= delta_d[i];
            end
        end
    end

    // Handshake and strobe are pure decodes of the state register.
    assign err_ready = (state_q == ACC);
    assign ctrl      = (state_q == UPDATE) ? CTRL_UPDATE : 4'b0000;
    assign sel       = (state_q == UPDATE) ? CTRL_UPDATE : 4'b0000;
    assign deltab2_1 = delta_q[0];
    assign deltab2_2 = delta_q[1];
    assign deltab2_3 = delta_q[2];
    assign deltab2_4 = delta_q[3];
    assign deltab2_5 = delta_q[4];
    assign upd_cnt   = upd_cnt_q;

endmodule

// File: tb/tb_bias2_delta_gen.sv
// Self-checking bench for bias2_delta_gen: directed scenarios plus randomized
// traffic compared against a batch-level reference model.
module tb_bias2_delta_gen;

    localparam int BATCH    = 4;
    localparam int LR_SHIFT = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        err_valid;
    logic        err_ready;
    logic [31:0] err_1, err_2, err_3, err_4, err_5;
    logic        flush;
    logic [3:0]  ctrl, sel;
    logic [15:0] deltab2_1, deltab2_2, deltab2_3, deltab2_4, deltab2_5;
    logic [15:0] upd_cnt;
    logic [15:0] dut_d [5];

    always #5 clk = ~clk;

    bias2_delta_gen #(
        .BATCH    (BATCH),
        .LR_SHIFT (LR_SHIFT),
        .ERR_W    (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .err_valid (err_valid),
        .err_ready (err_ready),
        .err_1     (err_1),
        .err_2     (err_2),
        .err_3     (err_3),
        .err_4     (err_4),
        .err_5     (err_5),
        .flush     (flush),
        .ctrl      (ctrl),
        .sel       (sel),
        .deltab2_1 (deltab2_1),
        .deltab2_2 (deltab2_2),
        .deltab2_3 (deltab2_3),
        .deltab2_4 (deltab2_4),
        .deltab2_5 (deltab2_5),
        .upd_cnt   (upd_cnt)
    );

    assign dut_d[0] = deltab2_1;
    assign dut_d[1] = deltab2_2;
    assign dut_d[2] = deltab2_3;
    assign dut_d[3] = deltab2_4;
    assign dut_d[4] = deltab2_5;

    int n_checks = 0;
    int n_fail   = 0;
    int strobe_cnt = 0;

    // Driven stimulus
    bit          drv_valid, drv_flush, drv_rst;
    logic [31:0] drv_err [5];

    // Reference model: batch sums as plain integers, bubble countdown after a batch closes
    longint      m_sum   [5];
    int          m_cnt;
    int          m_bubble;
    logic [15:0] m_pend  [5];
    logic [15:0] m_delta [5];
    logic [15:0] m_upd;
    bit          m_acc;

    always @(negedge clk) begin
        if (ctrl === 4'b1111 && sel === 4'b1111) strobe_cnt++;
    end

    // floor(sum / 2^LR_SHIFT), clamped to signed 16 bits
    function automatic logic [15:0] ref_delta(input longint s);
        longint div, q;
        div = longint'(1) << LR_SHIFT;
        q = s / div;
        if ((s % div) != 0 && s < 0) q = q - 1;
        if (q > 32767)  q = 32767;
        if (q < -32768) q = -32768;
        return 16'(q);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 5; i++) begin
            m_sum[i]   = 0;
            m_pend[i]  = '0;
            m_delta[i] = '0;
        end
        m_cnt = 0; m_bubble = 0; m_upd = '0;
    endtask

    // One clock: apply inputs, advance model to match the post-edge state
    task automatic tick();
        bit rdy;
        rst = drv_rst; err_valid = drv_valid; flush = drv_flush;
        err_1 = drv_err[0]; err_2 = drv_err[1]; err_3 = drv_err[2];
        err_4 = drv_err[3]; err_5 = drv_err[4];
        rdy   = (m_bubble == 0);
        m_acc = drv_valid && rdy && !drv_rst;
        @(posedge clk);
        #1;
        if (drv_rst) begin
            model_clear();
        end else if (rdy) begin
            if (m_acc) begin
                for (int i = 0; i < 5; i++) m_sum[i] += longint'($signed(drv_err[i]));
                m_cnt++;
            end
            if ((m_acc && m_cnt == BATCH) || (drv_flush && m_cnt > 0)) begin
                for (int i = 0; i < 5; i++) m_pend[i] = ref_delta(m_sum[i]);
                m_bubble = 2;
            end
        end else if (m_bubble == 2) begin
            for (int i = 0; i < 5; i++) m_delta[i] = m_pend[i];
            m_bubble = 1;
        end else begin
            m_upd = m_upd + 16'd1;
            for (int i = 0; i < 5; i++) m_sum[i] = 0;
            m_cnt = 0;
            m_bubble = 0;
        end
    endtask

    task automatic feed(input bit v, input bit f, input logic [31:0] a, b, c, d, e);
        drv_valid = v; drv_flush = f; drv_rst = 1'b0;
        drv_err[0] = a; drv_err[1] = b; drv_err[2] = c; drv_err[3] = d; drv_err[4] = e;
        tick();
    endtask

    task automatic idle();
        feed(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    endtask

    task automatic do_reset();
        drv_rst = 1'b1; drv_valid = 1'b0; drv_flush = 1'b0;
        for (int i = 0; i < 5; i++) drv_err[i] = '0;
        tick();
        drv_rst = 1'b0;
    endtask

    // Four back-to-back vectors, then one idle: ends observing the UPDATE cycle
    task automatic batch4(input logic [31:0] a, b, c, d, e);
        for (int k = 0; k < 4; k++) feed(1'b1, 1'b0, a, b, c, d, e);
        idle();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (err_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", err_ready); end
        n_checks++;
        if (ctrl !== 4'b0000 || sel !== 4'b0000) begin
            n_fail++; $display("FAIL reset_ctrl: got ctrl=%b sel=%b expected 0000", ctrl, sel);
        end
        n_checks++;
        if ({deltab2_1, deltab2_2, deltab2_3, deltab2_4, deltab2_5} !== 80'd0) begin
            n_fail++; $display("FAIL reset_deltas: got %h %h %h %h %h expected 0",
                               deltab2_1, deltab2_2, deltab2_3, deltab2_4, deltab2_5);
        end
        n_checks++;
        if (upd_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_updcnt: got %0d expected 0", upd_cnt); end
    endtask

    task automatic test_nominal();
        do_reset();
        strobe_cnt = 0;
        for (int k = 0; k < 4; k++) feed(1'b1, 1'b0, 32'd64, 32'hFFFF_FFC0, 32'd0, 32'd0, 32'd0);
        n_checks++;
        if (ctrl !== 4'b0000 || err_ready !== 1'b0) begin
            n_fail++; $display("FAIL nominal_scale: got ctrl=%b ready=%b expected 0000/0", ctrl, err_ready);
        end
        idle();
        n_checks++;
        if (ctrl !== 4'b1111 || sel !== 4'b1111) begin
            n_fail++; $display("FAIL nominal_strobe: got ctrl=%b sel=%b expected 1111", ctrl, sel);
        end
        n_checks++;
        if (deltab2_1 !== 16'd4) begin n_fail++; $display("FAIL nominal_d1: got %h expected 0004", deltab2_1); end
        n_checks++;
        if (deltab2_2 !== 16'hFFFC) begin n_fail++; $display("FAIL nominal_d2: got %h expected fffc", deltab2_2); end
        n_checks++;
        if ({deltab2_3, deltab2_4, deltab2_5} !== 48'd0) begin
            n_fail++; $display("FAIL nominal_d345: got %h %h %h expected 0", deltab2_3, deltab2_4, deltab2_5);
        end
        idle();
        n_checks++;
        if (err_ready !== 1'b1 || ctrl !== 4'b0000) begin
            n_fail++; $display("FAIL nominal_return: got ready=%b ctrl=%b expected 1/0000", err_ready, ctrl);
        end
        n_checks++;
        if (upd_cnt !== 16'd1) begin n_fail++; $display("FAIL nominal_updcnt: got %0d expected 1", upd_cnt); end
        idle(); idle();
        n_checks++;
        if (strobe_cnt !== 1) begin n_fail++; $display("FAIL nominal_strobe_count: got %0d expected 1", strobe_cnt); end
        n_checks++;
        if (deltab2_1 !== 16'd4) begin n_fail++; $display("FAIL nominal_hold: got %h expected 0004", deltab2_1); end
    endtask

    task automatic test_rounding();
        do_reset();
        batch4(32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0);
        n_checks++;
        if (deltab2_3 !== 16'hFFFF) begin n_fail++; $display("FAIL round_neg: got %h expected ffff", deltab2_3); end
        idle();
        batch4(32'd0, 32'd0, 32'd1, 32'd0, 32'd0);
        n_checks++;
        if (deltab2_3 !== 16'd0) begin n_fail++; $display("FAIL round_pos: got %h expected 0000", deltab2_3); end
        idle();
    endtask

    task automatic test_saturation();
        do_reset();
        batch4(32'h7FFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0);
        n_checks++;
        if (deltab2_1 !== 16'h7FFF) begin n_fail++; $display("FAIL sat_pos: got %h expected 7fff", deltab2_1); end
        idle();
        batch4(32'h8000_0000, 32'd0, 32'd0, 32'd0, 32'd0);
        n_checks++;
        if (deltab2_1 !== 16'h8000) begin n_fail++; $display("FAIL sat_neg: got %h expected 8000", deltab2_1); end
        idle();
    endtask

    task automatic test_flush();
        do_reset();
        strobe_cnt = 0;
        feed(1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 32'd128, 32'd0);
        feed(1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 32'd128, 32'd0);
        feed(1'b0, 1'b1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        n_checks++;
        if (ctrl !== 4'b0000 || err_ready !== 1'b0) begin
            n_fail++; $display("FAIL flush_scale: got ctrl=%b ready=%b expected 0000/0", ctrl, err_ready);
        end
        idle();
        n_checks++;
        if (ctrl !== 4'b1111 || deltab2_4 !== 16'd4) begin
            n_fail++; $display("FAIL flush_partial: got ctrl=%b d4=%h expected 1111/0004", ctrl, deltab2_4);
        end
        idle();
        // Flush with an empty batch must be ignored
        feed(1'b0, 1'b1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        n_checks++;
        if (err_ready !== 1'b1) begin n_fail++; $display("FAIL flush_empty_ready: got %b expected 1", err_ready); end
        idle(); idle(); idle();
        n_checks++;
        if (strobe_cnt !== 1) begin n_fail++; $display("FAIL flush_empty_strobe: got %0d expected 1", strobe_cnt); end
        // Flush coincident with the 3rd accept includes that sample
        feed(1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd64);
        feed(1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd64);
        feed(1'b1, 1'b1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd64);
        idle();
        n_checks++;
        if (ctrl !== 4'b1111 || deltab2_5 !== 16'd3) begin
            n_fail++; $display("FAIL flush_with_accept: got ctrl=%b d5=%h expected 1111/0003", ctrl, deltab2_5);
        end
        idle();
        n_checks++;
        if (upd_cnt !== 16'd2) begin n_fail++; $display("FAIL flush_updcnt: got %0d expected 2", upd_cnt); end
    endtask

    task automatic test_backpressure();
        logic [31:0] base [5];
        logic [31:0] step [5];
        logic [3:0]  exp_ctrl;
        int seq = 0;
        int strobes = 0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            base[i] = (i < 2) ? 32'($urandom_range(0, 4000)) - 32'd2000 : $urandom;
            step[i] = (i < 2) ? 32'($urandom_range(0, 2000)) - 32'd1000 : $urandom;
        end
        drv_valid = 1'b1; drv_flush = 1'b0; drv_rst = 1'b0;
        for (int c = 0; c < 40 && strobes < 3; c++) begin
            for (int i = 0; i < 5; i++) drv_err[i] = base[i] + 32'(seq) * step[i];
            tick();
            if (m_acc) seq++;
            n_checks++;
            if (err_ready !== (m_bubble == 0)) begin
                n_fail++; $display("FAIL bp_ready cyc %0d: got %b expected %b", c, err_ready, (m_bubble == 0));
            end
            exp_ctrl = (m_bubble == 1) ? 4'b1111 : 4'b0000;
            n_checks++;
            if (ctrl !== exp_ctrl || sel !== exp_ctrl) begin
                n_fail++; $display("FAIL bp_strobe cyc %0d: got ctrl=%b sel=%b expected %b", c, ctrl, sel, exp_ctrl);
            end
            if (m_bubble == 1) begin
                strobes++;
                for (int i = 0; i < 5; i++) begin
                    n_checks++;
                    if (dut_d[i] !== m_delta[i]) begin
                        n_fail++; $display("FAIL bp_delta batch %0d lane %0d: got %h expected %h",
                                           strobes, i + 1, dut_d[i], m_delta[i]);
                    end
                end
            end
        end
        drv_valid = 1'b0;
        n_checks++;
        if (strobes != 3) begin n_fail++; $display("FAIL bp_timeout: got %0d batches expected 3", strobes); end
        idle();
        n_checks++;
        if (upd_cnt !== m_upd) begin n_fail++; $display("FAIL bp_updcnt: got %0d expected %0d", upd_cnt, m_upd); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        batch4(32'd640, 32'd0, 32'd0, 32'd0, 32'd0);
        idle();
        for (int k = 0; k < 4; k++) feed(1'b1, 1'b0, 32'd64, 32'd0, 32'd0, 32'd0, 32'd0);
        // Now in SCALE: reset here must kill the pending strobe
        strobe_cnt = 0;
        do_reset();
        n_checks++;
        if (err_ready !== 1'b1 || ctrl !== 4'b0000 || sel !== 4'b0000) begin
            n_fail++; $display("FAIL rstmid_ctrl: got ready=%b ctrl=%b sel=%b expected 1/0000/0000", err_ready, ctrl, sel);
        end
        n_checks++;
        if ({deltab2_1, deltab2_2, deltab2_3, deltab2_4, deltab2_5} !== 80'd0 || upd_cnt !== 16'd0) begin
            n_fail++; $display("FAIL rstmid_outputs: got d1=%h upd=%0d expected 0/0", deltab2_1, upd_cnt);
        end
        idle(); idle(); idle();
        n_checks++;
        if (strobe_cnt !== 0) begin n_fail++; $display("FAIL rstmid_nostrobe: got %0d expected 0", strobe_cnt); end
        batch4(32'd64, 32'd0, 32'd0, 32'd0, 32'd0);
        n_checks++;
        if (ctrl !== 4'b1111 || deltab2_1 !== 16'd4) begin
            n_fail++; $display("FAIL rstmid_next_batch: got ctrl=%b d1=%h expected 1111/0004", ctrl, deltab2_1);
        end
        idle();
        n_checks++;
        if (upd_cnt !== 16'd1) begin n_fail++; $display("FAIL rstmid_updcnt: got %0d expected 1", upd_cnt); end
    endtask

    task automatic test_random();
        logic [3:0] exp_ctrl;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            drv_valid = ($urandom_range(0, 3) != 0);
            drv_flush = ($urandom_range(0, 9) == 0);
            drv_rst   = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < 5; i++) begin
                drv_err[i] = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 8191)) - 32'd4096;
            end
            tick();
            exp_ctrl = (m_bubble == 1) ? 4'b1111 : 4'b0000;
            n_checks++;
            if (err_ready !== (m_bubble == 0)) begin
                n_fail++; $display("FAIL rnd_ready cyc %0d: got %b expected %b", c, err_ready, (m_bubble == 0));
            end
            n_checks++;
            if (ctrl !== exp_ctrl || sel !== exp_ctrl) begin
                n_fail++; $display("FAIL rnd_strobe cyc %0d: got ctrl=%b sel=%b expected %b", c, ctrl, sel, exp_ctrl);
            end
            for (int i = 0; i < 5; i++) begin
                n_checks++;
                if (dut_d[i] !== m_delta[i]) begin
                    n_fail++; $display("FAIL rnd_delta cyc %0d lane %0d: got %h expected %h", c, i + 1, dut_d[i], m_delta[i]);
                end
            end
            n_checks++;
            if (upd_cnt !== m_upd) begin
                n_fail++; $display("FAIL rnd_updcnt cyc %0d: got %0d expected %0d", c, upd_cnt, m_upd);
            end
        end
        drv_rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; err_valid = 1'b0; flush = 1'b0;
        err_1 = '0; err_2 = '0; err_3 = '0; err_4 = '0; err_5 = '0;
        drv_valid = 1'b0; drv_flush = 1'b0; drv_rst = 1'b0;
        for (int i = 0; i < 5; i++) drv_err[i] = '0;
        model_clear();

        test_reset();
        test_nominal();
        test_rounding();
        test_saturation();
        test_flush();
        test_backpressure();
        test_reset_mid();
        test_random();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
